// File: rtl/controlado_memoria_if.sv
// Bus bundle between the board-RAM arbiter and its clients / the two player RAMs.
// slave: the arbiter side; master: whatever drives client requests and RAM read data.
interface controlado_memoria_if #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 5
);
  logic [DW-1:0] data_memoria_jogadorUm;
  logic [DW-1:0] data_memoria_jogadorDois;

  logic          readyValidador;
  logic          validador_wrep1;
  logic          validador_wrep2;
  logic          validadoJogador;
  logic [AW-1:0] validador_addr;
  logic [DW-1:0] validador_data;

  logic          readyColisor;
  logic          colisor_wrep1;
  logic          colisor_wrep2;
  logic          jogadorColisor;
  logic [AW-1:0] colisor_addr;
  logic [DW-1:0] colisor_data;

  logic          readyCalculaPontuacao;
  logic [AW-1:0] pontuacao_readaddr;
  logic          jogadorPontuacao;

  logic [AW-1:0] vga_readAddr;
  logic          jogadorVGA;

  logic [DW-1:0] dataReadValidador;
  logic [DW-1:0] dataReadColisor;
  logic [DW-1:0] dataReadVGA;
  logic [DW-1:0] dataReadPontuacao;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;
  logic          wrenP1;
  logic          wrenP2;

  modport slave (
    input  data_memoria_jogadorUm, data_memoria_jogadorDois,
    input  readyValidador, validador_wrep1, validador_wrep2, validadoJogador,
    input  validador_addr, validador_data,
    input  readyColisor, colisor_wrep1, colisor_wrep2, jogadorColisor,
    input  colisor_addr, colisor_data,
    input  readyCalculaPontuacao, pontuacao_readaddr, jogadorPontuacao,
    input  vga_readAddr, jogadorVGA,
    output dataReadValidador, dataReadColisor, dataReadVGA, dataReadPontuacao,
    output data, addr, wrenP1, wrenP2
  );

  modport master (
    output data_memoria_jogadorUm, data_memoria_jogadorDois,
    output readyValidador, validador_wrep1, validador_wrep2, validadoJogador,
    output validador_addr, validador_data,
    output readyColisor, colisor_wrep1, colisor_wrep2, jogadorColisor,
    output colisor_addr, colisor_data,
    output readyCalculaPontuacao, pontuacao_readaddr, jogadorPontuacao,
    output vga_readAddr, jogadorVGA,
    input  dataReadValidador, dataReadColisor, dataReadVGA, dataReadPontuacao,
    input  data, addr, wrenP1, wrenP2
  );
endinterface

// File: rtl/controlado_memoria.sv
// Fixed-priority arbiter/mux for the two player board RAMs (validador > colisor > pontuacao > VGA).
// Define MEMCTRL_OUTREG_EN to register addr/data/wren (adds one cycle of write and read latency).
module controlado_memoria #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 5
) (
  input logic                  clk,
  input logic                  resetGeral,
  controlado_memoria_if.slave  bus
);

  typedef enum logic [1:0] {GntVga, GntPont, GntCol, GntVal} grantT;

`ifdef MEMCTRL_OUTREG_EN
  localparam int unsigned Stages = 2;
`else
  localparam int unsigned Stages = 1;
`endif
  localparam int unsigned Last = Stages - 1;

  grantT         grant;
  logic          sel;
  logic [AW-1:0] addrC;
  logic [DW-1:0] dataC;
  logic          wrenP1C;
  logic          wrenP2C;

  always_comb begin
    grant   = GntVga;
    sel     = bus.jogadorVGA;
    addrC   = bus.vga_readAddr;
    dataC   = '0;
    wrenP1C = 1'b0;
    wrenP2C = 1'b0;
    if (bus.readyValidador) begin
      grant   = GntVal;
      sel     = bus.validadoJogador;
      addrC   = bus.validador_addr;
      dataC   = bus.validador_data;
      wrenP1C = bus.validador_wrep1;
      wrenP2C = bus.validador_wrep2;
    end else if (bus.readyColisor) begin
      grant   = GntCol;
      sel     = bus.jogadorColisor;
      addrC   = bus.colisor_addr;
      dataC   = bus.colisor_data;
      wrenP1C = bus.colisor_wrep1;
      wrenP2C = bus.colisor_wrep2;
    end else if (bus.readyCalculaPontuacao) begin
      grant   = GntPont;
      sel     = bus.jogadorPontuacao;
      addrC   = bus.pontuacao_readaddr;
    end
  end

`ifdef MEMCTRL_OUTREG_EN
  logic [AW-1:0] addrQ;
  logic [DW-1:0] dataQ;
  logic          wrenP1Q;
  logic          wrenP2Q;

  always_ff @(posedge clk or negedge resetGeral) begin
    if (!resetGeral) begin
      addrQ   <= '0;
      dataQ   <= '0;
      wrenP1Q <= 1'b0;
      wrenP2Q <= 1'b0;
    end else begin
      addrQ   <= addrC;
      dataQ   <= dataC;
      wrenP1Q <= wrenP1C;
      wrenP2Q <= wrenP2C;
    end
  end

  assign bus.addr   = addrQ;
  assign bus.data   = dataQ;
  assign bus.wrenP1 = wrenP1Q;
  assign bus.wrenP2 = wrenP2Q;
`else
  assign bus.addr   = addrC;
  assign bus.data   = dataC;
  assign bus.wrenP1 = wrenP1C;
  assign bus.wrenP2 = wrenP2C;
`endif

  // Owner/select travel alongside the RAM access so the returning word lands
  // in the client that issued it, even if the grant has since moved.
  grantT         grantPipe [Stages];
  logic          selPipe   [Stages];
  logic          validPipe [Stages];
  logic [DW-1:0] ramData;
  logic [DW-1:0] readVal;
  logic [DW-1:0] readCol;
  logic [DW-1:0] readPont;
  logic [DW-1:0] readVga;

  assign ramData = selPipe[Last] ? bus.data_memoria_jogadorDois : bus.data_memoria_jogadorUm;

  always_ff @(posedge clk or negedge resetGeral) begin
    if (!resetGeral) begin
      for (int i = 0; i < Stages; i++) begin
        grantPipe[i] <= GntVga;
        selPipe[i]   <= 1'b0;
        validPipe[i] <= 1'b0;
      end
      readVal  <= '0;
      readCol  <= '0;
      readPont <= '0;
      readVga  <= '0;
    end else begin
      grantPipe[0] <= grant;
      selPipe[0]   <= sel;
      validPipe[0] <= 1'b1;
      for (int i = 1; i < Stages; i++) begin
        grantPipe[i] <= grantPipe[i-1];
        selPipe[i]   <= selPipe[i-1];
        validPipe[i] <= validPipe[i-1];
      end
      if (validPipe[Last]) begin
        unique case (grantPipe[Last])
          GntVal:  readVal  <= ramData;
          GntCol:  readCol  <= ramData;
          GntPont: readPont <= ramData;
          GntVga:  readVga  <= ramData;
        endcase
      end
    end
  end

  assign bus.dataReadValidador = readVal;
  assign bus.dataReadColisor   = readCol;
  assign bus.dataReadPontuacao = readPont;
  assign bus.dataReadVGA       = readVga;

endmodule

// File: tb/tb_controlado_memoria.sv
// Bench for controlado_memoria: directed steps plus random traffic against a
// transaction-level model (priority pick, memory arrays, fixed-latency return queue).
module tb_controlado_memoria;

`ifdef MEMCTRL_OUTREG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic clk;
  logic resetGeral;
  int   nChecks = 0;
  int   nPass   = 0;

  controlado_memoria_if #(.DW(64), .AW(5)) bus ();

  controlado_memoria #(.DW(64), .AW(5)) dut (
    .clk        (clk),
    .resetGeral (resetGeral),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Player RAMs: synchronous, read-first; preloaded while reset is held.
  logic [63:0] ramP1 [32];
  logic [63:0] ramP2 [32];
  always @(posedge clk) begin
    if (!resetGeral) begin
      for (int k = 0; k < 32; k++) begin
        ramP1[k] <= 64'(k);
        ramP2[k] <= (k == 3) ? 64'hA5 : 64'h0;
      end
    end else begin
      if (bus.wrenP1) ramP1[bus.addr] <= bus.data;
      if (bus.wrenP2) ramP2[bus.addr] <= bus.data;
    end
    bus.data_memoria_jogadorUm   <= ramP1[bus.addr];
    bus.data_memoria_jogadorDois <= ramP2[bus.addr];
  end

  // Reference model state
  logic [63:0] refMem [2][32];
  logic [63:0] expRead [4];      // 0 validador, 1 colisor, 2 pontuacao, 3 VGA
  logic        pendValid [Lat];
  int          pendClient [Lat];
  logic [63:0] pendVal [Lat];
`ifdef MEMCTRL_OUTREG_EN
  logic [4:0]  qAddr = '0;
  logic [63:0] qData = '0;
  logic        qW1 = 1'b0;
  logic        qW2 = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    assert (got === exp) nPass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic step();
    int          g;
    logic        s;
    logic [4:0]  a;
    logic [63:0] d;
    logic        w1;
    logic        w2;
    logic [4:0]  cA;
    logic [63:0] cD;
    logic        cW1;
    logic        cW2;
    logic [63:0] nv;
    d  = '0;
    w1 = 1'b0;
    w2 = 1'b0;
    nv = '0;
    if (bus.readyValidador) begin
      g = 0; s = bus.validadoJogador; a = bus.validador_addr;
      d = bus.validador_data; w1 = bus.validador_wrep1; w2 = bus.validador_wrep2;
    end else if (bus.readyColisor) begin
      g = 1; s = bus.jogadorColisor; a = bus.colisor_addr;
      d = bus.colisor_data; w1 = bus.colisor_wrep1; w2 = bus.colisor_wrep2;
    end else if (bus.readyCalculaPontuacao) begin
      g = 2; s = bus.jogadorPontuacao; a = bus.pontuacao_readaddr;
    end else begin
      g = 3; s = bus.jogadorVGA; a = bus.vga_readAddr;
    end
`ifdef MEMCTRL_OUTREG_EN
    if (!resetGeral) begin
      cA = '0; cD = '0; cW1 = 1'b0; cW2 = 1'b0;
    end else begin
      cA = qAddr; cD = qData; cW1 = qW1; cW2 = qW2;
    end
`else
    cA = a; cD = d; cW1 = w1; cW2 = w2;
`endif
    @(negedge clk);
    check("addr", 64'(bus.addr), 64'(cA));
    check("data", bus.data, cD);
    check("wrenP1", 64'(bus.wrenP1), 64'(cW1));
    check("wrenP2", 64'(bus.wrenP2), 64'(cW2));
    if (resetGeral) begin
      nv = refMem[s][a];
      if (w1) refMem[0][a] = d;
      if (w2) refMem[1][a] = d;
    end
    @(posedge clk);
    #1;
    if (!resetGeral) begin
      for (int i = 0; i < 4; i++) expRead[i] = '0;
      for (int i = 0; i < Lat; i++) pendValid[i] = 1'b0;
`ifdef MEMCTRL_OUTREG_EN
      qAddr = '0; qData = '0; qW1 = 1'b0; qW2 = 1'b0;
`endif
    end else begin
      if (pendValid[Lat-1]) expRead[pendClient[Lat-1]] = pendVal[Lat-1];
      for (int i = Lat - 1; i > 0; i--) begin
        pendValid[i]  = pendValid[i-1];
        pendClient[i] = pendClient[i-1];
        pendVal[i]    = pendVal[i-1];
      end
      pendValid[0]  = 1'b1;
      pendClient[0] = g;
      pendVal[0]    = nv;
`ifdef MEMCTRL_OUTREG_EN
      qAddr = a; qData = d; qW1 = w1; qW2 = w2;
`endif
    end
    check("dataReadValidador", bus.dataReadValidador, expRead[0]);
    check("dataReadColisor", bus.dataReadColisor, expRead[1]);
    check("dataReadPontuacao", bus.dataReadPontuacao, expRead[2]);
    check("dataReadVGA", bus.dataReadVGA, expRead[3]);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      refMem[0][k] = 64'(k);
      refMem[1][k] = (k == 3) ? 64'hA5 : 64'h0;
    end
    for (int i = 0; i < 4; i++) expRead[i] = '0;
    for (int i = 0; i < Lat; i++) begin
      pendValid[i] = 1'b0; pendClient[i] = 0; pendVal[i] = '0;
    end
    resetGeral = 1'b0;
    bus.readyValidador = 0; bus.validador_wrep1 = 0; bus.validador_wrep2 = 0;
    bus.validadoJogador = 0; bus.validador_addr = '0; bus.validador_data = '0;
    bus.readyColisor = 0; bus.colisor_wrep1 = 0; bus.colisor_wrep2 = 0;
    bus.jogadorColisor = 0; bus.colisor_addr = '0; bus.colisor_data = '0;
    bus.readyCalculaPontuacao = 0; bus.pontuacao_readaddr = '0; bus.jogadorPontuacao = 0;
    bus.vga_readAddr = 5'd7; bus.jogadorVGA = 0;

    // Reset: everything zero, combinational bus follows VGA
    repeat (3) step();
    check("resetVGA", bus.dataReadVGA, 64'h0);
    resetGeral = 1'b1;

    // VGA sweep over P1 rows 0..11
    for (int k = 0; k < 12; k++) begin
      bus.vga_readAddr = 5'(k);
      step();
    end
    repeat (2) step();
    check("vgaSweepEnd", bus.dataReadVGA, 64'd11);

    // Validador reads P1 rows 0..11; VGA result held
    bus.readyValidador = 1; bus.validadoJogador = 0;
    for (int k = 0; k < 12; k++) begin
      bus.validador_addr = 5'(k);
      step();
    end
    repeat (2) step();
    check("vgaHeld", bus.dataReadVGA, 64'd11);

    // Validador write all-ones to P1 row 5, then VGA reads it back
    bus.validador_wrep1 = 1; bus.validador_addr = 5'd5;
    bus.validador_data = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    bus.validador_wrep1 = 0; bus.readyValidador = 0;
    bus.vga_readAddr = 5'd5; bus.jogadorVGA = 0;
    repeat (4) step();
    check("vgaRow5", bus.dataReadVGA, 64'hFFFF_FFFF_FFFF_FFFF);

    // Priority: colisor write blocked while validador is ready
    bus.readyValidador = 1; bus.validador_addr = 5'd2;
    bus.readyColisor = 1; bus.colisor_wrep2 = 1; bus.colisor_addr = 5'd9;
    bus.colisor_data = 64'h0123_4567_89AB_CDEF;
    step();
    bus.readyValidador = 0;
    step();
    bus.colisor_wrep2 = 0; bus.readyColisor = 0;

    // Pontuacao reads P2 row 3
    bus.readyCalculaPontuacao = 1; bus.jogadorPontuacao = 1; bus.pontuacao_readaddr = 5'd3;
    step();
    bus.readyCalculaPontuacao = 0;
    repeat (2) step();
    check("pontuacaoA5", bus.dataReadPontuacao, 64'hA5);

    // Random traffic
    repeat (400) begin
      bus.readyValidador        = ($urandom_range(3) == 0);
      bus.validador_wrep1       = 1'($urandom);
      bus.validador_wrep2       = 1'($urandom);
      bus.validadoJogador       = 1'($urandom);
      bus.validador_addr        = 5'($urandom);
      bus.validador_data        = {$urandom, $urandom};
      bus.readyColisor          = ($urandom_range(2) == 0);
      bus.colisor_wrep1         = 1'($urandom);
      bus.colisor_wrep2         = 1'($urandom);
      bus.jogadorColisor        = 1'($urandom);
      bus.colisor_addr          = 5'($urandom);
      bus.colisor_data          = {$urandom, $urandom};
      bus.readyCalculaPontuacao = 1'($urandom);
      bus.pontuacao_readaddr    = 5'($urandom);
      bus.jogadorPontuacao      = 1'($urandom);
      bus.vga_readAddr          = 5'($urandom);
      bus.jogadorVGA            = 1'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
